// File: rtl/uart_block_assembler.sv
// Purpose: packs UART receiver bytes into NUM_BYTES-wide blocks, first byte in the MSBs.
// Latency: block_valid rises on the edge that captures the final byte; all outputs registered.
// Backpressure: holds a full block until block_valid && block_ready; extra bytes are dropped with an overrun pulse.
// Optional inter-byte timeout for partial blocks: define UART_BLOCK_ASSEMBLER_TIMEOUT_EN.
module uart_block_assembler #(
  parameter int NUM_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   received,
  input  logic [7:0]             rx_byte,
  input  logic                   recv_error,
  output logic [8*NUM_BYTES-1:0] block_out,
  output logic                   block_valid,
  input  logic                   block_ready,
  output logic [4:0]             byte_count,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int         W        = 8 * NUM_BYTES;
  localparam logic [4:0] LAST_CNT = 5'(NUM_BYTES - 1);

  // Reject configurations the 5-bit byte counter or the idle counter cannot represent.
  if (NUM_BYTES < 2 || NUM_BYTES > 31 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_block_assembler: unsupported NUM_BYTES or TIMEOUT_CYCLES");
  end

  typedef enum logic {COLLECT, FULL} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   block_nxt;
  logic [4:0]     count_nxt;
  logic           valid_nxt;
  logic           overrun_nxt;
  logic           timeout_nxt;

`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] EXPIRE_AT = IW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0]  idle_cnt, idle_nxt;
`endif

  // Next-state and next-output logic; every target gets its hold/default value first.
  always_comb begin
    state_nxt   = state;
    block_nxt   = block_out;
    count_nxt   = byte_count;
    valid_nxt   = block_valid;
    overrun_nxt = 1'b0;
    timeout_nxt = 1'b0;
`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
    idle_nxt    = '0;
`endif
    case (state)
      COLLECT: begin
        if (recv_error) begin
          // A framing error poisons the partial block, including any byte arriving with it.
          block_nxt = '0;
          count_nxt = '0;
        end else if (received) begin
          block_nxt = {block_out[W-9:0], rx_byte};
          count_nxt = byte_count + 5'd1;
          if (byte_count == LAST_CNT) begin
            state_nxt = FULL;
            valid_nxt = 1'b1;
          end
`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
        end else if (byte_count != 5'd0) begin
          // The edge on which the idle count would reach TIMEOUT_CYCLES discards the partial block.
          if (idle_cnt == EXPIRE_AT) begin
            block_nxt   = '0;
            count_nxt   = '0;
            timeout_nxt = 1'b1;
          end else begin
            idle_nxt = idle_cnt + 1'b1;
          end
`endif
        end
      end
      FULL: begin
`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
        idle_nxt = idle_cnt;
`endif
        // recv_error is ignored here so a completed block is never lost.
        if (block_ready) begin
          state_nxt = COLLECT;
          valid_nxt = 1'b0;
          if (received) begin
            // Old data stays in the upper bytes; it is shifted out by the new block.
            block_nxt = {block_out[W-9:0], rx_byte};
            count_nxt = 5'd1;
          end else begin
            count_nxt = 5'd0;
          end
        end else if (received) begin
          overrun_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      block_out   <= '0;
      block_valid <= 1'b0;
      byte_count  <= 5'd0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      block_out   <= block_nxt;
      block_valid <= valid_nxt;
      byte_count  <= count_nxt;
      overrun     <= overrun_nxt;
      timeout     <= timeout_nxt;
    end
  end

`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
  // Idle cycle counter for the partial block currently being collected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_block_assembler.sv
// Randomized and directed bench for uart_block_assembler with a queue-based reference model.
// Completed blocks are scoreboarded and checked by a separate monitor at transfer time.
// Per-cycle outputs are compared against the model one time unit after each clock edge.
module tb_uart_block_assembler;

  localparam int N  = 16;
  localparam int TC = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             received = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             recv_error = 1'b0;
  logic             block_ready = 1'b0;
  logic [8*N-1:0]   block_out;
  logic             block_valid;
  logic [4:0]       byte_count;
  logic             overrun;
  logic             timeout;

  uart_block_assembler #(.NUM_BYTES(N), .TIMEOUT_CYCLES(TC)) dut (
    .clk         (clk),
    .rst         (rst),
    .received    (received),
    .rx_byte     (rx_byte),
    .recv_error  (recv_error),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .byte_count  (byte_count),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the block in arrival order, plus flags.
  logic [7:0]     q_bytes[$];
  bit             m_full  = 1'b0;
  bit             m_known = 1'b1;   // upper unfilled bytes are known to be zero
  bit             m_ovr   = 1'b0;
  bit             m_to    = 1'b0;
  int             m_idle  = 0;
  logic [8*N-1:0] sb[$];

  task automatic check(input string name, input logic [8*N-1:0] act, input logic [8*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8*N-1:0] low_packed(input bit want_mask);
    logic [8*N-1:0] v = '0;
    int sz = q_bytes.size();
    for (int i = 0; i < sz; i++) begin
      v[8*(sz-1-i) +: 8] = want_mask ? 8'hFF : q_bytes[i];
    end
    return v;
  endfunction

  task automatic model_reset();
    q_bytes.delete();
    sb.delete();
    m_full = 0; m_known = 1; m_ovr = 0; m_to = 0; m_idle = 0;
  endtask

  task automatic model_step(input logic r, input logic [7:0] b, input logic e, input logic y);
    m_ovr = 0;
    m_to  = 0;
    if (m_full) begin
      if (y) begin
        m_full = 0;
        m_known = 0;
        q_bytes.delete();
        if (r) q_bytes.push_back(b);
      end else if (r) begin
        m_ovr = 1;
      end
      m_idle = 0;
    end else if (e) begin
      q_bytes.delete();
      m_known = 1;
      m_idle = 0;
    end else if (r) begin
      q_bytes.push_back(b);
      m_idle = 0;
      if (q_bytes.size() == N) begin
        m_full = 1;
        sb.push_back(low_packed(1'b0));
      end
    end else if (q_bytes.size() > 0) begin
`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
      m_idle++;
      if (m_idle == TC) begin
        q_bytes.delete();
        m_known = 1;
        m_idle = 0;
        m_to = 1;
      end
`endif
    end
  endtask

  task automatic check_cycle();
    check("byte_count", 128'(byte_count), 128'(q_bytes.size()));
    check("block_valid", 128'(block_valid), 128'(m_full));
    check("overrun", 128'(overrun), 128'(m_ovr));
    check("timeout", 128'(timeout), 128'(m_to));
    if (m_known || m_full) check("block_out", block_out, low_packed(1'b0));
    else check("block_out_low", block_out & low_packed(1'b1), low_packed(1'b0));
  endtask

  // Drive one cycle of inputs, advance the model, and compare after the edge.
  task automatic cycle(input logic r, input logic [7:0] b, input logic e, input logic y);
    received = r; rx_byte = b; recv_error = e; block_ready = y;
    model_step(r, b, e, y);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic send_bytes(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) cycle(1'b1, first + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Assert rst between clock edges and confirm outputs clear before the next edge.
  task automatic async_reset();
    received = 0; recv_error = 0; block_ready = 0; rx_byte = 8'h00;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_cycle();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  // Monitor: every handshake must match the oldest outstanding expected block.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && block_valid && block_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL transfer_unexpected actual=%h expected=none", block_out);
        end else begin
          logic [8*N-1:0] e;
          e = sb.pop_front();
          if (block_out !== e) begin
            errors++;
            $display("FAIL transfer_block actual=%h expected=%h", block_out, e);
          end
        end
      end
    end
  end

  initial begin
    logic [127:0] t1_exp;
    logic [127:0] t4_exp;
    t1_exp = 128'h000102030405060708090A0B0C0D0E0F;
    t4_exp = 128'h101112131415161718191A1B1C1D1E1F;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cycle();
    rst = 1'b0;

    // Block of 0x00..0x0F held with ready low.
    send_bytes(16, 8'h00);
    check("t1_block", block_out, t1_exp);
    // Extra byte while full is dropped, then one-cycle transfer.
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("t2_held", block_out, t1_exp);
    idle_cycles(1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    // Transfer with a simultaneous byte.
    send_bytes(16, 8'h40);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    check("t3_lsb", 128'(block_out[7:0]), 128'h55);
    recv_error = 0;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // Error after 5 bytes, then a clean block.
    send_bytes(5, 8'h70);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    send_bytes(16, 8'h10);
    check("t4_block", block_out, t4_exp);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);   // error ignored while full, block transferred
    // Inter-byte idle window.
    send_bytes(3, 8'h20);
    idle_cycles(TC);
`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
    check("t5_expired_count", 128'(byte_count), 128'd0);
`else
    check("t5_kept_count", 128'(byte_count), 128'd3);
`endif
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    send_bytes(3, 8'h30);
    idle_cycles(TC - 2);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    idle_cycles(5);
    check("t5_refreshed_count", 128'(byte_count), 128'd4);
    send_bytes(3, 8'h34);
    idle_cycles(TC - 1);
    cycle(1'b1, 8'h37, 1'b0, 1'b0);   // byte lands on the expiry cycle
    check("t5_expiry_byte_count", 128'(byte_count), 128'd8);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // Asynchronous reset mid-block and while full.
    send_bytes(9, 8'h80);
    async_reset();
    send_bytes(16, 8'h90);
    async_reset();
    send_bytes(16, 8'hA0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, e, y;
      r = ($urandom_range(0, 99) < 55);
      e = ($urandom_range(0, 99) < 4);
      y = ($urandom_range(0, 99) < 30);
      cycle(r, 8'($urandom), e, y);
    end

    // Drain any pending block.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
